// File: rtl/egress_grant_arb.sv
// Egress-side grant arbiter: round-robin grant to one requesting ingress per attempt,
// regrant on decline/timeout, pointer advances only on an accepted grant.
module egress_grant_arb #(
  parameter int N_PORTS        = 4,
  parameter int ACCEPT_TIMEOUT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sched_start,
  input  logic [N_PORTS-1:0]         ingress_req,
  input  logic                       egress_busy,
  input  logic                       accept,
  input  logic                       decline,
  output logic                       grant_valid,
  output logic [$clog2(N_PORTS)-1:0] grant_idx,
  output logic [N_PORTS-1:0]         grant_vec,
  output logic                       matched,
  output logic [$clog2(N_PORTS)-1:0] matched_idx,
  output logic [$clog2(N_PORTS)-1:0] grant_ptr,
  output logic                       iter_done
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} state_t;

  state_t             state_reg;
  logic [N_PORTS-1:0] decline_mask_reg;
  logic [CNT_W-1:0]   timeout_cnt_reg;

  logic [N_PORTS-1:0] cand;
  logic [IDX_W-1:0]   rot_idx [N_PORTS];
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  assign cand = ingress_req & ~decline_mask_reg;

  // rot_idx[k] is the ingress with k-th highest priority this round
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_rot
      assign rot_idx[gi] = grant_ptr + IDX_W'(gi);
    end
  endgenerate

  // Scan lowest priority first so the highest-priority requester overwrites
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (cand[rot_idx[k]]) begin
        pick_idx   = rot_idx[k];
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      decline_mask_reg <= '0;
      timeout_cnt_reg  <= '0;
      grant_valid      <= 1'b0;
      grant_idx        <= '0;
      grant_vec        <= '0;
      matched          <= 1'b0;
      matched_idx      <= '0;
      grant_ptr        <= '0;
      iter_done        <= 1'b0;
    end else begin
      iter_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sched_start) begin
            matched          <= 1'b0;
            matched_idx      <= '0;
            decline_mask_reg <= '0;
            state_reg        <= ARB;
          end
        end
        ARB: begin
          if (egress_busy || !pick_found) begin
            iter_done <= 1'b1;
            state_reg <= DONE;
          end else begin
            grant_idx       <= pick_idx;
            grant_vec       <= N_PORTS'(1) << pick_idx;
            grant_valid     <= 1'b1;
            timeout_cnt_reg <= '0;
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            matched     <= 1'b1;
            matched_idx <= grant_idx;
            grant_ptr   <= grant_idx + IDX_W'(1);
            grant_valid <= 1'b0;
            grant_vec   <= '0;
            iter_done   <= 1'b1;
            state_reg   <= DONE;
          end else if (decline || timeout_cnt_reg == CNT_LAST) begin
            // a silent grant is treated exactly like a decline
            decline_mask_reg[grant_idx] <= 1'b1;
            grant_valid                 <= 1'b0;
            grant_vec                   <= '0;
            state_reg                   <= ARB;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
